// File: rtl/stress_trend_detector_pkg.sv
// Shared types and helpers for the heart-stress trend detector.
// Holds the FSM state encoding, the default sample width and the tolerance helper.
package stress_pkg;

  localparam int HART_W = 6;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Unsigned magnitude of a - b; operands are zero-extended samples.
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/stress_trend_detector_if.sv
// Sampler-to-detector-to-consumer bundle: heart-rate sample in, stability and trend results out.
interface stress_trend_detector_if
  import stress_pkg::*;
#(
  parameter int W = HART_W
);
  logic [W-1:0] hart;
  logic         stable_pulse;
  logic [W-1:0] stable_val;
  logic         gedaald;
  logic         error;
  logic [W:0]   delta;
  logic         first_seen;

  modport master (
    output hart,
    input  stable_pulse, stable_val, gedaald, error, delta, first_seen
  );

  modport slave (
    input  hart,
    output stable_pulse, stable_val, gedaald, error, delta, first_seen
  );
endinterface

// File: rtl/stress_trend_detector_window.sv
// Sample history of DEPTH-1 entries plus a fill counter, so post-reset zeros never count as samples.
// match is formed from the registered history against the live sample so a fire lands one cycle later.
module sample_window
  import stress_pkg::*;
#(
  parameter int W     = HART_W,
  parameter int DEPTH = 4
) (
  input  logic         slow,
  input  logic         resetSlower,
  input  logic [W-1:0] hart,
  output logic         match,
  output logic         fill_reach
);

  localparam int            CW   = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH - 1);

  logic [W-1:0]    hist_reg  [DEPTH-1];
  logic [W-1:0]    hist_next [DEPTH-1];
  logic [DEPTH-2:0] eq;
  logic [CW-1:0]   fill_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH - 1; gi++) begin : g_hist
      if (gi == 0) begin : g_head
        assign hist_next[gi] = hart;
      end else begin : g_tail
        assign hist_next[gi] = hist_reg[gi-1];
      end
      assign eq[gi] = (hist_reg[gi] == hart);
    end
  endgenerate

  always_ff @(posedge slow or posedge resetSlower) begin
    if (resetSlower) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        hist_reg[i] <= '0;
      end
      fill_reg <= '0;
    end else begin
      hist_reg <= hist_next;
      if (fill_reg != FULL) begin
        fill_reg <= fill_reg + 1'b1;
      end
    end
  end

  assign match = (&eq) && (fill_reg == FULL);
  // True on the edge where the counter reaches DEPTH-1, so the FSM is waiting on the DEPTH-th sample.
  assign fill_reach = (int'(fill_reg) + 2) >= DEPTH;

endmodule

// File: rtl/stress_trend_detector.sv
// Qualifies a heart-rate sample as stable after DEPTH equal samples and reports the trend
// against the previous stable value: one-cycle pulse, held dropped/rose flags and signed delta.
module stress_trend_detector
  import stress_pkg::*;
#(
  parameter int W     = HART_W,
  parameter int DEPTH = 4,
  parameter int TOL   = 0,
  parameter int REARM = 7
) (
  input logic                    slow,
  input logic                    resetSlower,
  stress_trend_detector_if.slave bus
);

  localparam int RW = $clog2(REARM + 1);

  state_t          state_reg, state_next;
  logic [RW-1:0]   rearm_reg, rearm_next;
  logic            fire;
  logic            match;
  logic            fill_reach;

  logic            pulse_reg;
  logic [W-1:0]    stable_val_reg;
  logic            gedaald_reg;
  logic            error_reg;
  logic [W:0]      delta_reg;
  logic            first_seen_reg;

  logic [W:0]      diff;
  logic [31:0]     mag;
  logic            beyond_tol;

  sample_window #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_window (
    .slow        (slow),
    .resetSlower (resetSlower),
    .hart        (bus.hart),
    .match       (match),
    .fill_reach  (fill_reach)
  );

  always_comb begin
    state_next = state_reg;
    rearm_next = rearm_reg;
    fire       = 1'b0;
    case (state_reg)
      ST_FILL: begin
        if (fill_reach) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (match) begin
          fire       = 1'b1;
          state_next = ST_HOLD;
          rearm_next = '0;
        end
      end
      ST_HOLD: begin
        // A sample change always wins over a rearm expiry in the same cycle.
        if (match) begin
          if (int'(rearm_reg) + 1 == REARM) begin
            fire       = 1'b1;
            rearm_next = '0;
          end else begin
            rearm_next = rearm_reg + 1'b1;
          end
        end else begin
          state_next = ST_WAIT;
          rearm_next = '0;
        end
      end
      default: state_next = ST_FILL;
    endcase
  end

  // Zero-extended subtraction cannot overflow in W+1 bits.
  assign diff       = {1'b0, bus.hart} - {1'b0, stable_val_reg};
  assign mag        = abs_diff(32'(bus.hart), 32'(stable_val_reg));
  assign beyond_tol = mag > 32'($unsigned(TOL));

  always_ff @(posedge slow or posedge resetSlower) begin
    if (resetSlower) begin
      state_reg      <= ST_FILL;
      rearm_reg      <= '0;
      pulse_reg      <= 1'b0;
      stable_val_reg <= '0;
      gedaald_reg    <= 1'b0;
      error_reg      <= 1'b0;
      delta_reg      <= '0;
      first_seen_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      rearm_reg <= rearm_next;
      pulse_reg <= fire;
      if (fire) begin
        stable_val_reg <= bus.hart;
        if (first_seen_reg) begin
          delta_reg   <= diff;
          gedaald_reg <= diff[W] && beyond_tol;
          error_reg   <= !diff[W] && beyond_tol;
        end else begin
          first_seen_reg <= 1'b1;
          delta_reg      <= '0;
          gedaald_reg    <= 1'b0;
          error_reg      <= 1'b0;
        end
      end
    end
  end

  assign bus.stable_pulse = pulse_reg;
  assign bus.stable_val   = stable_val_reg;
  assign bus.gedaald      = gedaald_reg;
  assign bus.error        = error_reg;
  assign bus.delta        = delta_reg;
  assign bus.first_seen   = first_seen_reg;

endmodule

// File: tb/tb_stress_trend_detector.sv
// Bench for stress_trend_detector: three configurations checked every cycle against a
// run-length model, plus directed literal expectations for the documented scenarios.
module tb_stress_trend_detector;

  localparam int PW [3] = '{6, 6, 8};
  localparam int PD [3] = '{4, 4, 2};
  localparam int PT [3] = '{0, 2, 0};
  localparam int PR [3] = '{7, 3, 5};

  logic slow = 1'b0;
  logic rst  = 1'b1;
  int   h [3];

  always #5 slow = ~slow;

  stress_trend_detector_if #(.W(6)) bus0 ();
  stress_trend_detector_if #(.W(6)) bus1 ();
  stress_trend_detector_if #(.W(8)) bus2 ();

  assign bus0.hart = 6'(h[0]);
  assign bus1.hart = 6'(h[1]);
  assign bus2.hart = 8'(h[2]);

  stress_trend_detector #(.W(6), .DEPTH(4), .TOL(0), .REARM(7)) dut0 (
    .slow(slow), .resetSlower(rst), .bus(bus0));
  stress_trend_detector #(.W(6), .DEPTH(4), .TOL(2), .REARM(3)) dut1 (
    .slow(slow), .resetSlower(rst), .bus(bus1));
  stress_trend_detector #(.W(8), .DEPTH(2), .TOL(0), .REARM(5)) dut2 (
    .slow(slow), .resetSlower(rst), .bus(bus2));

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: length of the current run of equal samples since reset, plus held results.
  int m_run [3], m_last [3], m_fs [3], m_sv [3], m_pulse [3], m_ged [3], m_err [3], m_dl [3];
  int a_pulse [3], a_sv [3], a_ged [3], a_err [3], a_dl [3], a_fs [3];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear(input int i);
    m_run[i] = 0; m_last[i] = 0; m_fs[i] = 0; m_sv[i] = 0;
    m_pulse[i] = 0; m_ged[i] = 0; m_err[i] = 0; m_dl[i] = 0;
  endtask

  task automatic model_step(input int i, input int v, input logic r);
    int  d;
    bit  fire;
    if (r) begin
      model_clear(i);
    end else begin
      if (m_run[i] > 0 && v == m_last[i]) m_run[i]++;
      else begin
        m_run[i]  = 1;
        m_last[i] = v;
      end
      fire = (m_run[i] == PD[i]) ||
             (m_run[i] > PD[i] && ((m_run[i] - PD[i]) % PR[i]) == 0);
      m_pulse[i] = fire ? 1 : 0;
      if (fire) begin
        if (m_fs[i] != 0) begin
          d        = v - m_sv[i];
          m_dl[i]  = d;
          m_ged[i] = (d < -PT[i]) ? 1 : 0;
          m_err[i] = (d > PT[i]) ? 1 : 0;
        end else begin
          m_fs[i]  = 1;
          m_dl[i]  = 0;
          m_ged[i] = 0;
          m_err[i] = 0;
        end
        m_sv[i] = v;
      end
    end
  endtask

  task automatic snap();
    a_pulse[0] = int'(bus0.stable_pulse); a_sv[0] = int'(bus0.stable_val);
    a_ged[0]   = int'(bus0.gedaald);      a_err[0] = int'(bus0.error);
    a_dl[0]    = int'($signed(bus0.delta)); a_fs[0] = int'(bus0.first_seen);
    a_pulse[1] = int'(bus1.stable_pulse); a_sv[1] = int'(bus1.stable_val);
    a_ged[1]   = int'(bus1.gedaald);      a_err[1] = int'(bus1.error);
    a_dl[1]    = int'($signed(bus1.delta)); a_fs[1] = int'(bus1.first_seen);
    a_pulse[2] = int'(bus2.stable_pulse); a_sv[2] = int'(bus2.stable_val);
    a_ged[2]   = int'(bus2.gedaald);      a_err[2] = int'(bus2.error);
    a_dl[2]    = int'($signed(bus2.delta)); a_fs[2] = int'(bus2.first_seen);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) model_clear(i);
  end

  // Single compare process: advance the model on each edge, then check all outputs.
  always @(posedge slow) begin
    for (int i = 0; i < 3; i++) model_step(i, h[i] & ((1 << PW[i]) - 1), rst);
    #1;
    snap();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("i%0d_pulse", i),      a_pulse[i], m_pulse[i]);
      chk($sformatf("i%0d_stable_val", i), a_sv[i],    m_sv[i]);
      chk($sformatf("i%0d_gedaald", i),    a_ged[i],   m_ged[i]);
      chk($sformatf("i%0d_error", i),      a_err[i],   m_err[i]);
      chk($sformatf("i%0d_delta", i),      a_dl[i],    m_dl[i]);
      chk($sformatf("i%0d_first_seen", i), a_fs[i],    m_fs[i]);
      if (a_pulse[i] != 0)
        $display("i%0d t=%0t stable_val=%0d delta=%0d gedaald=%0d error=%0d",
                 i, $time, a_sv[i], a_dl[i], a_ged[i], a_err[i]);
    end
  end

  task automatic drive(input int a, input int b, input int c);
    h[0] = a; h[1] = b; h[2] = c;
  endtask

  task automatic tick();
    @(posedge slow);
    #2;
  endtask

  task automatic cyc(input int a, input int b, input int c);
    @(negedge slow);
    drive(a, b, c);
    tick();
  endtask

  initial begin
    int first_p, second_p, n_p, nv;
    drive(0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    chk("rst_pulse", int'(bus0.stable_pulse), 0);
    chk("rst_first_seen", int'(bus0.first_seen), 0);
    chk("rst_delta", int'(bus0.delta), 0);

    // 1: first qualified value, pulse after the fourth equal sample
    @(negedge slow);
    rst = 1'b0;
    drive(20, 15, 0);
    tick();
    for (int k = 0; k < 3; k++) cyc(20, 15, 0);
    chk("t1_pulse", int'(bus0.stable_pulse), 1);
    chk("t1_first_seen", int'(bus0.first_seen), 1);
    chk("t1_delta", int'(bus0.delta), 0);
    chk("t1_flags", int'({bus0.gedaald, bus0.error}), 0);
    chk("t1_val", int'(bus0.stable_val), 20);

    // 2: drop 20->15; TOL=2 instance sees 15->16 as no trend; W=8 sees 0->255
    for (int k = 0; k < 4; k++) cyc(15, 16, 255);
    chk("t2_pulse", int'(bus0.stable_pulse), 1);
    chk("t2_delta_bits", int'(bus0.delta), 7'b1111011);
    chk("t2_gedaald", int'(bus0.gedaald), 1);
    chk("t2_error", int'(bus0.error), 0);
    chk("tol_delta", int'($signed(bus1.delta)), 1);
    chk("tol_flags", int'({bus1.gedaald, bus1.error}), 0);
    chk("w8_up_delta", int'(bus2.delta), 255);
    chk("w8_up_error", int'(bus2.error), 1);

    cyc(7, 16, 0);
    chk("t2_hold_gedaald", int'(bus0.gedaald), 1);
    chk("t2_hold_pulse", int'(bus0.stable_pulse), 0);
    cyc(30, 16, 0);
    chk("w8_down_bits", int'(bus2.delta), 9'h101);
    chk("w8_down_gedaald", int'(bus2.gedaald), 1);

    // 3: rise 15->30
    for (int k = 0; k < 3; k++) cyc(30, 16, 0);
    chk("t3_pulse", int'(bus0.stable_pulse), 1);
    chk("t3_error", int'(bus0.error), 1);
    chk("t3_gedaald", int'(bus0.gedaald), 0);
    chk("t3_delta", int'(bus0.delta), 15);

    // 4: continued stability re-fires every REARM cycles and clears flags
    first_p = -1; second_p = -1; n_p = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(30, 16, 0);
      if (bus0.stable_pulse) begin
        n_p++;
        if (first_p < 0) first_p = k;
        else if (second_p < 0) second_p = k;
      end
    end
    chk("t4_pulse_count", n_p, 2);
    chk("t4_spacing", second_p - first_p, 7);
    chk("t4_error_cleared", int'(bus0.error), 0);

    // 5: alternating samples never qualify; one deviation restarts the count
    n_p = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(10 + (k % 2), 16, 0);
      n_p += int'(bus0.stable_pulse);
    end
    chk("t5_toggle_pulses", n_p, 0);
    for (int k = 0; k < 3; k++) cyc(10, 16, 0);
    cyc(99 % 64, 16, 0);
    for (int k = 0; k < 3; k++) cyc(10, 16, 0);
    chk("t5_no_early_pulse", int'(bus0.stable_pulse), 0);
    cyc(10, 16, 0);
    chk("t5_pulse", int'(bus0.stable_pulse), 1);
    chk("t5_delta", int'($signed(bus0.delta)), -20);

    // 6: reset in HOLD clears everything at once, next value takes the first-seen path
    cyc(10, 16, 0);
    cyc(10, 16, 0);
    @(negedge slow);
    rst = 1'b1;
    #1;
    chk("t6_async_val", int'(bus0.stable_val), 0);
    chk("t6_async_delta", int'(bus0.delta), 0);
    chk("t6_async_gedaald", int'(bus0.gedaald), 0);
    chk("t6_async_first_seen", int'(bus0.first_seen), 0);
    tick();
    tick();
    @(negedge slow);
    rst = 1'b0;
    drive(40, 40, 40);
    tick();
    for (int k = 0; k < 3; k++) cyc(40, 40, 40);
    chk("t6_pulse", int'(bus0.stable_pulse), 1);
    chk("t6_first_seen", int'(bus0.first_seen), 1);
    chk("t6_delta", int'(bus0.delta), 0);
    chk("t6_flags", int'({bus0.gedaald, bus0.error}), 0);

    // Randomised runs with occasional resets, checked by the compare process
    for (int n = 0; n < 3000; n++) begin
      @(negedge slow);
      rst = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 3) == 0) begin
            h[i] = int'($urandom_range(0, (1 << PW[i]) - 1));
          end else begin
            nv = h[i] + int'($urandom_range(0, 6)) - 3;
            if (nv < 0) nv = 0;
            if (nv > (1 << PW[i]) - 1) nv = (1 << PW[i]) - 1;
            h[i] = nv;
          end
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
